tcam_ctrl: RTL

Request sequencer in front of the `tcam` array. It accepts entry updates and search requests from two independent valid/ready requesters. It arbitrates between them round-robin, drives the TCAM write and search ports from registers, and returns each search result on a valid/ready response channel. It also owns an optional flush sequence that rewrites every entry, and keeps a per-entry valid bitmap for software.

---
 rtl/tcam_pkg.sv | 17 +
 rtl/tcam_ctrl_arb.sv | 39 +++
 rtl/tcam_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// tcam_pkg
//   Shared definitions for the TCAM request sequencer: controller state
//   encoding and the default key/data width and entry count.
package tcam_pkg;

  localparam int TCAM_WIDTH = 8;
  localparam int TCAM_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWAIT = 3'd1,
    SCAP  = 3'd2,
    RSP   = 3'd3,
    FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/tcam_ctrl_arb.sv
// tcam_ctrl_arb
//   Two-requester round-robin tie-breaker. A requester that is alone wins
//   immediately. When both request while enabled, the priority bit picks the
//   winner and then flips.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           arbitration allowed this cycle
//   req_upd_i      update requester valid
//   req_srch_i     search requester valid
//   gnt_upd_o      one-hot grant to update
//   gnt_srch_o     one-hot grant to search
module tcam_ctrl_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_upd_i,
  input  logic req_srch_i,
  output logic gnt_upd_o,
  output logic gnt_srch_o
);

  // p_q = 1: update wins the next contested cycle
  logic p_q, p_d;

  always_comb begin
    gnt_upd_o  = en_i & req_upd_i  & (~req_srch_i | p_q);
    gnt_srch_o = en_i & req_srch_i & (~req_upd_i  | ~p_q);
    p_d        = (en_i & req_upd_i & req_srch_i) ? ~p_q : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 1'b1;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/tcam_ctrl.sv
// tcam_ctrl
//   Request sequencer in front of a TCAM array. Arbitrates between an update
//   requester and a search requester, drives the registered TCAM write and
//   search ports, returns search results on a valid/ready channel and keeps
//   a per-entry "written" bitmap.
//   Build option TCAM_CTRL_FLUSH_EN: adds the flush sequence that rewrites
//   every entry with INIT_DATA/INIT_MASK. Without it flush_req is ignored and
//   flush_busy is tied low.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   upd_valid/upd_ready              update handshake
//   upd_addr/upd_data/upd_mask       update payload
//   srch_valid/srch_ready, srch_key  search handshake and key
//   rsp_valid/rsp_ready              result handshake
//   rsp_found/rsp_data               registered search result
//   flush_req, flush_busy            flush request pulse, flush pending/active
//   entry_vld                        entries written since last flush/reset
//   t_wr_*                           TCAM write port (registered)
//   t_search_en/t_search_key         TCAM search port (registered)
//   t_match_found/t_match_data       TCAM result, one edge after search
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting updates and searches; may start a pending flush
// SWAIT | search issued to the TCAM, result not yet valid
// SCAP  | TCAM result valid, captured into rsp_* at the end of the cycle
// RSP   | response offered, waiting for rsp_ready
// FLUSH | writing INIT_* to one entry per cycle (flush build only)
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int WIDTH = TCAM_WIDTH,
  parameter int DEPTH = TCAM_DEPTH,
  parameter logic [WIDTH-1:0] INIT_DATA = '0,
  parameter logic [WIDTH-1:0] INIT_MASK = '1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [AW-1:0]    upd_addr,
  input  logic [WIDTH-1:0] upd_data,
  input  logic [WIDTH-1:0] upd_mask,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [WIDTH-1:0] srch_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_found,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [DEPTH-1:0] entry_vld,
  output logic             t_wr_en,
  output logic [AW-1:0]    t_wr_addr,
  output logic [WIDTH-1:0] t_wr_data,
  output logic [WIDTH-1:0] t_wr_mask,
  output logic             t_search_en,
  output logic [WIDTH-1:0] t_search_key,
  input  logic             t_match_found,
  input  logic [WIDTH-1:0] t_match_data
);

  state_e state_q, state_d;

  logic             t_wr_en_q, t_wr_en_d;
  logic [AW-1:0]    t_wr_addr_q, t_wr_addr_d;
  logic [WIDTH-1:0] t_wr_data_q, t_wr_data_d;
  logic [WIDTH-1:0] t_wr_mask_q, t_wr_mask_d;
  logic             t_search_en_q, t_search_en_d;
  logic [WIDTH-1:0] t_search_key_q, t_search_key_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_found_q, rsp_found_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DEPTH-1:0] entry_vld_q, entry_vld_d;

  logic flush_pend;
  logic arb_en, gnt_upd, gnt_srch;
  logic upd_acc, srch_acc;

`ifdef TCAM_CTRL_FLUSH_EN
  logic          flush_busy_q, flush_busy_d;
  // address currently presented on the write port during FLUSH
  logic [AW-1:0] flush_cnt_q, flush_cnt_d;

  assign flush_pend = flush_busy_q;
  assign flush_busy = flush_busy_q;
`else
  logic unused_flush;

  assign flush_pend   = 1'b0;
  assign flush_busy   = 1'b0;
  assign unused_flush = flush_req ^ (^INIT_DATA) ^ (^INIT_MASK);
`endif

  assign arb_en = rst_n & (state_q == IDLE) & ~flush_pend;

  tcam_ctrl_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (arb_en),
    .req_upd_i  (upd_valid),
    .req_srch_i (srch_valid),
    .gnt_upd_o  (gnt_upd),
    .gnt_srch_o (gnt_srch)
  );

  // Outside IDLE the search side cannot be accepted, so updates are
  // uncontested there; in IDLE an update is only refused when search wins.
  assign srch_ready = arb_en & ~gnt_upd;
  assign upd_ready  = rst_n & ~flush_pend & (state_q != FLUSH) &
                      ((state_q != IDLE) | ~gnt_srch);

  assign upd_acc  = upd_valid & upd_ready;
  assign srch_acc = srch_valid & srch_ready;

  always_comb begin
    state_d        = state_q;
    t_wr_en_d      = 1'b0;
    t_wr_addr_d    = t_wr_addr_q;
    t_wr_data_d    = t_wr_data_q;
    t_wr_mask_d    = t_wr_mask_q;
    t_search_en_d  = 1'b0;
    t_search_key_d = t_search_key_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_found_d    = rsp_found_q;
    rsp_data_d     = rsp_data_q;
    entry_vld_d    = entry_vld_q;
`ifdef TCAM_CTRL_FLUSH_EN
    flush_busy_d   = flush_busy_q;
    flush_cnt_d    = flush_cnt_q;
`endif

    if (upd_acc) begin
      t_wr_en_d             = 1'b1;
      t_wr_addr_d           = upd_addr;
      t_wr_data_d           = upd_data;
      t_wr_mask_d           = upd_mask;
      entry_vld_d[upd_addr] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (srch_acc) begin
          t_search_en_d  = 1'b1;
          t_search_key_d = srch_key;
          state_d        = SWAIT;
        end
`ifdef TCAM_CTRL_FLUSH_EN
        // Wait for a write issued last cycle to leave the port before
        // the flush takes it over; the first flush write goes out on entry.
        else if (flush_busy_q && !t_wr_en_q) begin
          state_d     = FLUSH;
          entry_vld_d = '0;
          t_wr_en_d   = 1'b1;
          t_wr_addr_d = '0;
          t_wr_data_d = INIT_DATA;
          t_wr_mask_d = INIT_MASK;
          flush_cnt_d = '0;
        end
`endif
      end
      SWAIT: state_d = SCAP;
      SCAP: begin
        rsp_valid_d = 1'b1;
        rsp_found_d = t_match_found;
        rsp_data_d  = t_match_data;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef TCAM_CTRL_FLUSH_EN
      FLUSH: begin
        if (flush_cnt_q == AW'(DEPTH - 1)) begin
          state_d      = IDLE;
          flush_busy_d = 1'b0;
        end else begin
          t_wr_en_d   = 1'b1;
          t_wr_addr_d = flush_cnt_q + AW'(1);
          t_wr_data_d = INIT_DATA;
          t_wr_mask_d = INIT_MASK;
          flush_cnt_d = flush_cnt_q + AW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef TCAM_CTRL_FLUSH_EN
    if (flush_req && !flush_busy_q) begin
      flush_busy_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      t_wr_en_q      <= 1'b0;
      t_wr_addr_q    <= '0;
      t_wr_data_q    <= '0;
      t_wr_mask_q    <= '0;
      t_search_en_q  <= 1'b0;
      t_search_key_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_found_q    <= 1'b0;
      rsp_data_q     <= '0;
      entry_vld_q    <= '0;
`ifdef TCAM_CTRL_FLUSH_EN
      flush_busy_q   <= 1'b0;
      flush_cnt_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      t_wr_en_q      <= t_wr_en_d;
      t_wr_addr_q    <= t_wr_addr_d;
      t_wr_data_q    <= t_wr_data_d;
      t_wr_mask_q    <= t_wr_mask_d;
      t_search_en_q  <= t_search_en_d;
      t_search_key_q <= t_search_key_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_found_q    <= rsp_found_d;
      rsp_data_q     <= rsp_data_d;
      entry_vld_q    <= entry_vld_d;
`ifdef TCAM_CTRL_FLUSH_EN
      flush_busy_q   <= flush_busy_d;
      flush_cnt_q    <= flush_cnt_d;
`endif
    end
  end

  assign t_wr_en      = t_wr_en_q;
  assign t_wr_addr    = t_wr_addr_q;
  assign t_wr_data    = t_wr_data_q;
  assign t_wr_mask    = t_wr_mask_q;
  assign t_search_en  = t_search_en_q;
  assign t_search_key = t_search_key_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_found    = rsp_found_q;
  assign rsp_data     = rsp_data_q;
  assign entry_vld    = entry_vld_q;

endmodule
